img_play_ctrl: RTL and testbench

- Frame playback controller for the RGB565 simulation/image platform.
- Sequences raster timing and read addressing of a synchronous pixel store (1-cycle read latency), then emits an aligned vs/de/data stream to the downstream processing chain.
- Adds start/stop control, a programmable frame count, frame-done signalling and pipeline drain. Timing is generated only while the block is running.

---
 rtl/img_play_ctrl.sv | 172 +++++++++++++++++
 tb/tb_img_play_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_play_ctrl.sv
// Frame playback controller: raster timing + pixel-store read addressing, emits aligned vs/de/data.
// Latency: 3 cycles from raster position to vs/de/data; frame_done and busy are registered state flags.
// Backpressure: none; downstream must accept every cycle; stop takes effect only at a frame boundary.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, stop     single-cycle control pulses (stop wins if both arrive in IDLE)
//   cfg_frames      number of frames to play, latched on an accepted start (0 = continuous)
//   rd_en, rd_addr  pixel store read strobe / address; rd_data returns one cycle later
//   vs, de, data    aligned output stream; data is forced to 0 whenever de is low
//   frame_done      high on the last cycle of every played frame
//   busy            high while running or draining
module img_play_ctrl #(
    parameter int ACTIVE_IW = 640,
    parameter int ACTIVE_IH = 480,
    parameter int TOTAL_IW  = 800,
    parameter int TOTAL_IH  = 525,
    parameter int H_START   = 143,
    parameter int V_START   = 34,
    parameter int VS_LEN    = 2,
    parameter int AW        = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    cfg_frames,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic          vs,
    output logic          de,
    output logic [15:0]   data,
    output logic          frame_done,
    output logic          busy
);

    localparam int HW = $clog2(TOTAL_IW);
    localparam int VW = $clog2(TOTAL_IH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(ACTIVE_IW * ACTIVE_IH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [7:0]    frames_cfg;
    logic [7:0]    frame_cnt;
    logic          stop_pending;
    logic [1:0]    drain_cnt;
    logic          vs_raw;
    logic          rd_en_d1;
    logic          vs_d1;

    logic h_last;
    logic h_prelast;
    logic v_last;
    logic in_active;
    logic last_frame;

    assign h_last    = (int'(hcnt) == TOTAL_IW - 1);
    assign h_prelast = (int'(hcnt) == TOTAL_IW - 2);
    assign v_last    = (int'(vcnt) == TOTAL_IH - 1);
    assign in_active = (int'(hcnt) >= H_START) && (int'(hcnt) < H_START + ACTIVE_IW) &&
                       (int'(vcnt) >= V_START) && (int'(vcnt) < V_START + ACTIVE_IH);
    // frame_cnt counts completed frames, so the frame now ending is frame_cnt+1
    assign last_frame = (frames_cfg != 8'd0) && ((frame_cnt + 8'd1) == frames_cfg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hcnt         <= '0;
            vcnt         <= '0;
            frames_cfg   <= '0;
            frame_cnt    <= '0;
            stop_pending <= 1'b0;
            drain_cnt    <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            vs_raw       <= 1'b0;
            rd_en_d1     <= 1'b0;
            vs_d1        <= 1'b0;
            vs           <= 1'b0;
            de           <= 1'b0;
            data         <= '0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Output pipeline runs in every state so DRAIN can flush it.
            rd_en_d1 <= rd_en;
            de       <= rd_en_d1;
            data     <= rd_en_d1 ? rd_data : 16'h0000;
            vs_d1    <= vs_raw;
            vs       <= vs_d1;

            rd_en      <= 1'b0;
            vs_raw     <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    hcnt         <= '0;
                    vcnt         <= '0;
                    rd_addr      <= '0;
                    drain_cnt    <= '0;
                    stop_pending <= 1'b0;
                    if (start && !stop) begin
                        frames_cfg <= cfg_frames;
                        frame_cnt  <= '0;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end
                end

                RUN: begin
                    rd_en  <= in_active;
                    vs_raw <= (int'(vcnt) >= VS_LEN);
                    // Registered one cycle early so the pulse lines up with the frame-end cycle.
                    frame_done <= h_prelast && v_last;

                    if (rd_en) begin
                        rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + AW'(1);
                    end

                    if (stop) begin
                        stop_pending <= 1'b1;
                    end

                    if (h_last) begin
                        hcnt <= '0;
                        vcnt <= v_last ? '0 : vcnt + VW'(1);
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end

                    if (h_last && v_last) begin
                        rd_addr   <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                        // A stop sampled on this very cycle still ends the current frame.
                        if (stop_pending || stop || last_frame) begin
                            state        <= DRAIN;
                            stop_pending <= 1'b0;
                            drain_cnt    <= '0;
                        end
                    end
                end

                DRAIN: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    // Three cycles let the last position's vs/de/data reach the outputs.
                    if (drain_cnt == 2'd2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_play_ctrl.sv
// Directed bench for img_play_ctrl using a tiny raster (8x5 total, 4x2 active, 40-cycle frames).
// Run index r counts cycles from the first RUN cycle after an accepted start.
// A behavioural pixel store returns pix(addr) one cycle after rd_en.
module tb_img_play_ctrl;

    localparam int IW  = 4;
    localparam int IH  = 2;
    localparam int TW  = 8;
    localparam int TH  = 5;
    localparam int HS  = 2;
    localparam int VSS = 1;
    localparam int VSL = 1;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    cfg_frames = 8'd0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = 16'h0000;
    logic          vs;
    logic          de;
    logic [15:0]   data;
    logic          frame_done;
    logic          busy;

    int vec = 0;
    int miscmp = 0;
    int cyc = 0;
    int r0 = 0;
    int bad_data = 0;
    bit mon_on = 1'b0;

    logic [15:0] de_q[$];
    int          de_cyc_q[$];
    int          addr_q[$];
    int          fd_q[$];

    // Run indices of the 8 de cycles in a frame: positions (v=1..2, h=2..5) plus 3 cycles latency.
    int exp_de_r[8] = '{13, 14, 15, 16, 21, 22, 23, 24};

    img_play_ctrl #(
        .ACTIVE_IW(IW), .ACTIVE_IH(IH), .TOTAL_IW(TW), .TOTAL_IH(TH),
        .H_START(HS), .V_START(VSS), .VS_LEN(VSL), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_frames(cfg_frames),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .vs(vs), .de(de), .data(data), .frame_done(frame_done), .busy(busy)
    );

    function automatic logic [15:0] pix(input int a);
        return 16'h1234 + 16'(a) * 16'h1111;
    endfunction

    function automatic bit act(input int p);
        int q;
        int h;
        int v;
        q = p % 40;
        h = q % TW;
        v = q / TW;
        return (v >= VSS) && (v < VSS + IH) && (h >= HS) && (h < HS + IW);
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= rd_en ? pix(int'(rd_addr)) : 16'hBAD0;

    // Advance one cycle and record observations well away from the clock edge.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        if (mon_on) begin
            if (de === 1'b1) begin
                de_q.push_back(data);
                de_cyc_q.push_back(cyc);
            end else if (data !== 16'h0000) begin
                bad_data++;
            end
            if (rd_en === 1'b1) addr_q.push_back(int'(rd_addr));
            if (frame_done === 1'b1) fd_q.push_back(cyc);
        end
    endtask

    task automatic clear_mon();
        de_q.delete();
        de_cyc_q.delete();
        addr_q.delete();
        fd_q.delete();
        bad_data = 0;
    endtask

    task automatic do_start(input logic [7:0] n);
        clear_mon();
        cfg_frames = n;
        start = 1'b1;
        step();
        start = 1'b0;
        r0 = cyc;
    endtask

    // Bounded wait for busy to fall; idle_r = -1 if it never does.
    task automatic wait_idle(input int budget, output int idle_r);
        idle_r = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (busy === 1'b0) begin
                idle_r = cyc - r0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        rst = 1'b1;
        repeat (3) step();
        outs = {rd_en, rd_addr, vs, de, data, frame_done, busy};
        vec++;
        if (outs !== 24'h0) begin
            miscmp++;
            $display("FAIL reset_outputs: got %h expected 000000", outs);
        end
        rst = 1'b0;
        repeat (3) step();
        outs = {rd_en, rd_addr, vs, de, data, frame_done, busy};
        vec++;
        if (outs !== 24'h0) begin
            miscmp++;
            $display("FAIL idle_outputs: got %h expected 000000", outs);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_single_frame();
        int idle_r;
        do_start(8'd1);
        vec++;
        if (busy !== 1'b1) begin
            miscmp++;
            $display("FAIL single_busy_r0: got %b expected 1", busy);
        end
        wait_idle(200, idle_r);
        vec++;
        if (idle_r != 43) begin
            miscmp++;
            $display("FAIL single_idle_cycle: got %0d expected 43", idle_r);
        end
        vec++;
        if (de_q.size() != 8) begin
            miscmp++;
            $display("FAIL single_de_count: got %0d expected 8", de_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (i >= de_q.size()) begin
                miscmp++;
                $display("FAIL single_pixel%0d: missing, expected data %h at r=%0d", i, pix(i), exp_de_r[i]);
            end else if (de_cyc_q[i] - r0 != exp_de_r[i] || de_q[i] !== pix(i)) begin
                miscmp++;
                $display("FAIL single_pixel%0d: got data %h at r=%0d expected %h at r=%0d",
                         i, de_q[i], de_cyc_q[i] - r0, pix(i), exp_de_r[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (i >= addr_q.size()) begin
                miscmp++;
                $display("FAIL single_addr%0d: missing, expected %0d", i, i);
            end else if (addr_q[i] != i) begin
                miscmp++;
                $display("FAIL single_addr%0d: got %0d expected %0d", i, addr_q[i], i);
            end
        end
        vec++;
        if (fd_q.size() != 1) begin
            miscmp++;
            $display("FAIL single_fd_count: got %0d expected 1", fd_q.size());
        end else if (fd_q[0] - r0 != 39) begin
            miscmp++;
            $display("FAIL single_fd_cycle: got r=%0d expected r=39", fd_q[0] - r0);
        end
        repeat (10) step();
        vec++;
        if (de_q.size() != 8 || busy !== 1'b0) begin
            miscmp++;
            $display("FAIL single_quiet_after: got de count %0d busy %b expected 8 and 0", de_q.size(), busy);
        end
        vec++;
        if (bad_data != 0) begin
            miscmp++;
            $display("FAIL single_data_gating: got %0d nonzero idle data cycles expected 0", bad_data);
        end
    endtask

    task automatic test_three_frames();
        int  idle_r;
        int  r;
        int  p;
        logic exp_vs;
        logic exp_de;
        do_start(8'd3);
        idle_r = -1;
        for (int i = 0; i < 300; i++) begin
            step();
            r = cyc - r0;
            p = r - 3;
            exp_vs = (p >= 0) && (p < 120) && ((p % 40) >= VSL * TW);
            exp_de = (p >= 0) && (p < 120) && act(p);
            vec++;
            if (vs !== exp_vs) begin
                miscmp++;
                $display("FAIL three_vs r=%0d: got %b expected %b", r, vs, exp_vs);
            end
            vec++;
            if (de !== exp_de) begin
                miscmp++;
                $display("FAIL three_de r=%0d: got %b expected %b", r, de, exp_de);
            end
            if (busy === 1'b0) begin
                idle_r = r;
                break;
            end
        end
        vec++;
        if (idle_r != 123) begin
            miscmp++;
            $display("FAIL three_idle_cycle: got %0d expected 123", idle_r);
        end
        vec++;
        if (fd_q.size() != 3) begin
            miscmp++;
            $display("FAIL three_fd_count: got %0d expected 3", fd_q.size());
        end
        for (int i = 0; i < 3 && i < fd_q.size(); i++) begin
            vec++;
            if (fd_q[i] - r0 != 39 + 40 * i) begin
                miscmp++;
                $display("FAIL three_fd%0d_cycle: got r=%0d expected r=%0d", i, fd_q[i] - r0, 39 + 40 * i);
            end
        end
        vec++;
        if (de_q.size() != 24 || addr_q.size() != 24) begin
            miscmp++;
            $display("FAIL three_counts: got de %0d reads %0d expected 24 and 24", de_q.size(), addr_q.size());
        end
        for (int i = 0; i < 24 && i < addr_q.size() && i < de_q.size(); i++) begin
            vec++;
            if (addr_q[i] != i % 8 || de_q[i] !== pix(i % 8)) begin
                miscmp++;
                $display("FAIL three_pixel%0d: got addr %0d data %h expected addr %0d data %h",
                         i, addr_q[i], de_q[i], i % 8, pix(i % 8));
            end
        end
    endtask

    task automatic test_continuous_stop();
        int idle_r;
        do_start(8'd0);
        while (cyc - r0 < 60) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(300, idle_r);
        vec++;
        if (idle_r != 83) begin
            miscmp++;
            $display("FAIL cont_stop_idle_cycle: got %0d expected 83", idle_r);
        end
        vec++;
        if (fd_q.size() != 2) begin
            miscmp++;
            $display("FAIL cont_stop_fd_count: got %0d expected 2", fd_q.size());
        end else if (fd_q[0] - r0 != 39 || fd_q[1] - r0 != 79) begin
            miscmp++;
            $display("FAIL cont_stop_fd_cycles: got r=%0d,%0d expected r=39,79", fd_q[0] - r0, fd_q[1] - r0);
        end
        vec++;
        if (de_q.size() != 16 || addr_q.size() != 16) begin
            miscmp++;
            $display("FAIL cont_stop_counts: got de %0d reads %0d expected 16 and 16", de_q.size(), addr_q.size());
        end
        for (int i = 0; i < 8 && 8 + i < addr_q.size(); i++) begin
            vec++;
            if (addr_q[8 + i] != i) begin
                miscmp++;
                $display("FAIL cont_stop_frame2_addr%0d: got %0d expected %0d", i, addr_q[8 + i], i);
            end
        end
    endtask

    task automatic test_stop_boundary();
        int idle_r;
        do_start(8'd0);
        while (cyc - r0 < 39) step();
        vec++;
        if (frame_done !== 1'b1) begin
            miscmp++;
            $display("FAIL boundary_fd_r39: got %b expected 1", frame_done);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(300, idle_r);
        vec++;
        if (idle_r != 43 || fd_q.size() != 1 || de_q.size() != 8) begin
            miscmp++;
            $display("FAIL boundary_one_frame: got idle r=%0d fd %0d de %0d expected 43, 1, 8",
                     idle_r, fd_q.size(), de_q.size());
        end
        // start and stop in the same IDLE cycle must not launch playback
        clear_mon();
        cfg_frames = 8'd1;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (busy !== 1'b0 || rd_en !== 1'b0) begin
                miscmp++;
                $display("FAIL start_stop_idle cycle%0d: got busy %b rd_en %b expected 0 0", i, busy, rd_en);
            end
            step();
        end
        vec++;
        if (de_q.size() != 0 || fd_q.size() != 0) begin
            miscmp++;
            $display("FAIL start_stop_idle_activity: got de %0d fd %0d expected 0 0", de_q.size(), fd_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int          idle_r;
        logic [23:0] outs;
        do_start(8'd1);
        while (cyc - r0 < 20) step();
        vec++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 3'd5) begin
            miscmp++;
            $display("FAIL midreset_pre_state: got busy %b rd_en %b addr %0d expected 1 1 5", busy, rd_en, rd_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        outs = {rd_en, rd_addr, vs, de, data, frame_done, busy};
        vec++;
        if (outs !== 24'h0) begin
            miscmp++;
            $display("FAIL midreset_outputs: got %h expected 000000", outs);
        end
        clear_mon();
        repeat (50) step();
        vec++;
        if (fd_q.size() != 0 || de_q.size() != 0 || busy !== 1'b0) begin
            miscmp++;
            $display("FAIL midreset_stays_idle: got fd %0d de %0d busy %b expected 0 0 0",
                     fd_q.size(), de_q.size(), busy);
        end
        do_start(8'd1);
        wait_idle(200, idle_r);
        vec++;
        if (idle_r != 43 || fd_q.size() != 1) begin
            miscmp++;
            $display("FAIL midreset_replay: got idle r=%0d fd %0d expected 43 1", idle_r, fd_q.size());
        end
        vec++;
        if (addr_q.size() != 8) begin
            miscmp++;
            $display("FAIL midreset_replay_reads: got %0d expected 8", addr_q.size());
        end else if (addr_q[0] != 0 || addr_q[7] != 7) begin
            miscmp++;
            $display("FAIL midreset_replay_addr: got first %0d last %0d expected 0 7", addr_q[0], addr_q[7]);
        end
    endtask

    task automatic test_ignored_start();
        int idle_r;
        do_start(8'd2);
        while (cyc - r0 < 50) step();
        cfg_frames = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - r0 < 81) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(300, idle_r);
        vec++;
        if (idle_r != 83) begin
            miscmp++;
            $display("FAIL ignored_idle_cycle: got %0d expected 83", idle_r);
        end
        vec++;
        if (fd_q.size() != 2) begin
            miscmp++;
            $display("FAIL ignored_fd_count: got %0d expected 2", fd_q.size());
        end else if (fd_q[0] - r0 != 39 || fd_q[1] - r0 != 79) begin
            miscmp++;
            $display("FAIL ignored_fd_cycles: got r=%0d,%0d expected r=39,79", fd_q[0] - r0, fd_q[1] - r0);
        end
        vec++;
        if (de_q.size() != 16) begin
            miscmp++;
            $display("FAIL ignored_de_count: got %0d expected 16", de_q.size());
        end
        for (int i = 0; i < 8 && 8 + i < de_cyc_q.size(); i++) begin
            vec++;
            if (de_cyc_q[8 + i] - r0 != 40 + exp_de_r[i]) begin
                miscmp++;
                $display("FAIL ignored_frame2_de%0d: got r=%0d expected r=%0d", i, de_cyc_q[8 + i] - r0, 40 + exp_de_r[i]);
            end
        end
        repeat (5) step();
        vec++;
        if (busy !== 1'b0) begin
            miscmp++;
            $display("FAIL ignored_no_restart: got busy %b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_three_frames();
        test_continuous_stop();
        test_stop_boundary();
        test_reset_mid_frame();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
